// File: rtl/mem_bus_arbiter.sv
// Registered round-robin arbiter between three memory masters (loader, cpu,
// reader) and a single memory port. One transaction at a time; a watchdog
// aborts transactions that memory never acknowledges.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no transaction; pick next requester starting at the rotation ptr
// BUSY  | mem_* driven and held; waiting for mem_response or watchdog
// DONE  | one-cycle response pulse to the granted master; advance ptr
module mem_bus_arbiter #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 16,
   parameter int TIMEOUT    = 255
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [2:0]              m_request,
   input  logic [2:0]              m_mode,
   input  logic [3*ADDR_WIDTH-1:0] m_locator,
   input  logic [3*DATA_WIDTH-1:0] m_write,
   output logic [2:0]              m_response,
   output logic                    m_error,
   output logic [DATA_WIDTH-1:0]   m_read,
   output logic                    mem_request,
   output logic                    mem_mode,
   output logic [ADDR_WIDTH-1:0]   mem_locator,
   output logic [DATA_WIDTH-1:0]   mem_write,
   input  logic                    mem_response,
   input  logic [DATA_WIDTH-1:0]   mem_read,
   output logic [1:0]              grant
);

   // Watchdog is sized to hold TIMEOUT itself so the terminal compare never wraps.
   localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                  state, state_nx;
   logic [1:0]              ptr, ptr_nx;
   logic [1:0]              grant_nx;
   logic [WD_W-1:0]         wd, wd_nx;
   logic                    mem_request_nx;
   logic                    mem_mode_nx;
   logic [ADDR_WIDTH-1:0]   mem_locator_nx;
   logic [DATA_WIDTH-1:0]   mem_write_nx;
   logic [2:0]              m_response_nx;
   logic                    m_error_nx;
   logic [DATA_WIDTH-1:0]   m_read_nx;

   logic                    sel_valid;
   logic [1:0]              sel_idx;

   // Master indices live in 0..2; sums of an index and an offset stay below 6.
   function automatic logic [1:0] wrap3(input logic [2:0] v);
      logic [2:0] r;
      r = (v >= 3'd3) ? (v - 3'd3) : v;
      return r[1:0];
   endfunction

   // Round-robin pick: scan ptr, ptr+1, ptr+2; lowest offset with a request wins.
   always_comb begin
      sel_valid = 1'b0;
      sel_idx   = 2'd0;
      for (int k = 2; k >= 0; k--) begin
         if (m_request[wrap3({1'b0, ptr} + 3'(k))]) begin
            sel_valid = 1'b1;
            sel_idx   = wrap3({1'b0, ptr} + 3'(k));
         end
      end
   end

   // Next-state and next-output logic; every output is registered below.
   always_comb begin
      state_nx       = state;
      ptr_nx         = ptr;
      grant_nx       = grant;
      wd_nx          = wd;
      mem_request_nx = mem_request;
      mem_mode_nx    = mem_mode;
      mem_locator_nx = mem_locator;
      mem_write_nx   = mem_write;
      m_response_nx  = 3'b000;
      m_error_nx     = 1'b0;
      m_read_nx      = m_read;

      case (state)
         IDLE: begin
            if (sel_valid) begin
               mem_request_nx = 1'b1;
               mem_mode_nx    = m_mode[sel_idx];
               mem_locator_nx = m_locator[int'(sel_idx)*ADDR_WIDTH +: ADDR_WIDTH];
               mem_write_nx   = m_write[int'(sel_idx)*DATA_WIDTH +: DATA_WIDTH];
               grant_nx       = sel_idx;
               wd_nx          = '0;
               state_nx       = BUSY;
            end else begin
               mem_request_nx = 1'b0;
               mem_mode_nx    = 1'b0;
               mem_locator_nx = '0;
               mem_write_nx   = '0;
            end
         end

         BUSY: begin
            if (mem_response || (wd == WD_LAST)) begin
               // Only a genuine read completion updates the shared read register.
               if (mem_response && !mem_mode) begin
                  m_read_nx = mem_read;
               end
               m_response_nx  = 3'b001 << grant;
               m_error_nx     = !mem_response;
               mem_request_nx = 1'b0;
               mem_mode_nx    = 1'b0;
               mem_locator_nx = '0;
               mem_write_nx   = '0;
               state_nx       = DONE;
            end else begin
               wd_nx = wd + 1'b1;
            end
         end

         DONE: begin
            ptr_nx   = wrap3({1'b0, grant} + 3'd1);
            state_nx = IDLE;
         end

         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         ptr         <= 2'd0;
         grant       <= 2'd0;
         wd          <= '0;
         mem_request <= 1'b0;
         mem_mode    <= 1'b0;
         mem_locator <= '0;
         mem_write   <= '0;
         m_response  <= 3'b000;
         m_error     <= 1'b0;
         m_read      <= '0;
      end else begin
         state       <= state_nx;
         ptr         <= ptr_nx;
         grant       <= grant_nx;
         wd          <= wd_nx;
         mem_request <= mem_request_nx;
         mem_mode    <= mem_mode_nx;
         mem_locator <= mem_locator_nx;
         mem_write   <= mem_write_nx;
         m_response  <= m_response_nx;
         m_error     <= m_error_nx;
         m_read      <= m_read_nx;
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a small memory responder and a
// scoreboard of expected completions (master, error flag, read data).
module tb_mem_bus_arbiter;

   localparam int AW = 16;
   localparam int DW = 16;
   localparam int TO = 4;

   logic            clk;
   logic            reset;
   logic [2:0]      m_request;
   logic [2:0]      m_mode;
   logic [3*AW-1:0] m_locator;
   logic [3*DW-1:0] m_write;
   logic [2:0]      m_response;
   logic            m_error;
   logic [DW-1:0]   m_read;
   logic            mem_request;
   logic            mem_mode;
   logic [AW-1:0]   mem_locator;
   logic [DW-1:0]   mem_write;
   logic            mem_response;
   logic [DW-1:0]   mem_read;
   logic [1:0]      grant;

   mem_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .m_request(m_request), .m_mode(m_mode), .m_locator(m_locator), .m_write(m_write),
      .m_response(m_response), .m_error(m_error), .m_read(m_read),
      .mem_request(mem_request), .mem_mode(mem_mode), .mem_locator(mem_locator),
      .mem_write(mem_write), .mem_response(mem_response), .mem_read(mem_read),
      .grant(grant)
   );

   typedef struct {
      int          idx;
      logic        err;
      logic [15:0] data;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   logic        ack_en     = 1'b0;
   int          ack_delay  = 0;
   logic [15:0] rd_data    = 16'h0000;
   logic        model_resp = 1'b0;
   logic        man_resp   = 1'b0;
   int          req_cycles = 0;

   assign mem_response = model_resp | man_resp;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory responder: acks ack_delay negedges after it first sees mem_request.
   always @(negedge clk) begin
      if (mem_request && ack_en) begin
         model_resp = (req_cycles == ack_delay);
         req_cycles = req_cycles + 1;
      end else begin
         model_resp = 1'b0;
         req_cycles = 0;
      end
   end
   assign mem_read = rd_data;

   initial begin
      #500000;
      $display("FAIL global_timeout: observed no end of test, expected finish");
      $fatal(1, "simulation time limit");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_req"},  32'(mem_request), 32'd0);
      check({tag, "_mode"}, 32'(mem_mode),    32'd0);
      check({tag, "_loc"},  32'(mem_locator), 32'd0);
      check({tag, "_wr"},   32'(mem_write),   32'd0);
      check({tag, "_resp"}, 32'(m_response),  32'd0);
      check({tag, "_err"},  32'(m_error),     32'd0);
   endtask

   task automatic set_master(input int i, input logic mode, input logic [15:0] loc,
                             input logic [15:0] wr);
      m_mode[i]              = mode;
      m_locator[i*AW +: AW]  = loc;
      m_write[i*DW +: DW]    = wr;
   endtask

   // Wait for a response pulse, compare it with the scoreboard head, then
   // confirm the pulse lasts exactly one cycle.
   task automatic wait_resp(input string tag, input int budget, output int lat);
      exp_t e;
      bit   seen;
      seen = 1'b0;
      lat  = 0;
      for (int i = 1; i <= budget; i++) begin
         @(negedge clk);
         if (m_response !== 3'b000) begin
            seen = 1'b1;
            lat  = i;
            break;
         end
      end
      n_cmp++;
      assert (seen) else begin
         n_err++;
         $error("FAIL %s_wait: observed no m_response within %0d cycles, expected a pulse", tag, budget);
      end
      if (seen) begin
         n_cmp++;
         assert (sb.size() > 0) else begin
            n_err++;
            $error("FAIL %s_sb: observed unexpected m_response %b, expected none", tag, m_response);
         end
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_resp"},  32'(m_response), 32'(3'b001 << e.idx));
            check({tag, "_grant"}, 32'(grant),      32'(e.idx));
            check({tag, "_err"},   32'(m_error),    32'(e.err));
            check({tag, "_read"},  32'(m_read),     32'(e.data));
         end
         @(negedge clk);
         check({tag, "_pulse_end"}, 32'(m_response), 32'd0);
         check({tag, "_err_end"},   32'(m_error),    32'd0);
      end
   endtask

   int          lat;
   logic [15:0] last_read;

   initial begin
      reset     = 1'b1;
      m_request = 3'b000;
      m_mode    = 3'b000;
      m_locator = '0;
      m_write   = '0;
      last_read = 16'h0000;
      repeat (2) @(negedge clk);
      check_quiet("reset");
      check("reset_read",  32'(m_read), 32'd0);
      check("reset_grant", 32'(grant),  32'd0);
      reset = 1'b0;

      // Single-master read with a delayed ack.
      ack_en = 1'b1; ack_delay = 2; rd_data = 16'hBEEF;
      set_master(1, 1'b0, 16'h0042, 16'h0000);
      m_request = 3'b010;
      sb.push_back('{idx: 1, err: 1'b0, data: 16'hBEEF});
      @(negedge clk);
      check("rd_memreq",  32'(mem_request), 32'd1);
      check("rd_loc",     32'(mem_locator), 32'h0042);
      check("rd_mode",    32'(mem_mode),    32'd0);
      m_request = 3'b000;
      wait_resp("rd", 20, lat);
      check("rd_lat", 32'(lat), 32'd3);
      last_read = 16'hBEEF;

      // Round-robin with all three requesting and an immediate ack.
      reset = 1'b1;
      ack_delay = 0; rd_data = 16'hA5A0;
      for (int i = 0; i < 3; i++) set_master(i, 1'b0, 16'(16'h0100 + i), 16'h0000);
      m_request = 3'b111;
      @(negedge clk);
      reset = 1'b0;
      last_read = 16'h0000;
      sb.push_back('{idx: 0, err: 1'b0, data: 16'hA5A0});
      sb.push_back('{idx: 1, err: 1'b0, data: 16'hA5A0});
      sb.push_back('{idx: 2, err: 1'b0, data: 16'hA5A0});
      sb.push_back('{idx: 0, err: 1'b0, data: 16'hA5A0});
      for (int t = 0; t < 3; t++) begin
         wait_resp("rr", 10, lat);
         check("rr_lat", 32'(lat), 32'd2);
      end
      @(negedge clk);
      check("rr4_loc", 32'(mem_locator), 32'h0100);
      m_request = 3'b000;
      wait_resp("rr4", 10, lat);
      check("rr4_lat", 32'(lat), 32'd1);
      last_read = 16'hA5A0;

      // Write passthrough: m_read keeps its previous value.
      ack_delay = 1;
      set_master(0, 1'b1, 16'h0010, 16'h1234);
      m_request = 3'b001;
      sb.push_back('{idx: 0, err: 1'b0, data: last_read});
      @(negedge clk);
      check("wr_mode", 32'(mem_mode),    32'd1);
      check("wr_data", 32'(mem_write),   32'h1234);
      check("wr_loc",  32'(mem_locator), 32'h0010);
      m_request = 3'b000;
      wait_resp("wr", 10, lat);
      check("wr_data_clr", 32'(mem_write),   32'd0);
      check("wr_req_clr",  32'(mem_request), 32'd0);

      // Timeout on master2, then master0 gets the next grant.
      ack_en = 1'b0;
      set_master(0, 1'b0, 16'h0020, 16'h0000);
      set_master(2, 1'b0, 16'h0030, 16'h0000);
      m_request = 3'b101;
      sb.push_back('{idx: 2, err: 1'b1, data: last_read});
      wait_resp("to", 20, lat);
      check("to_lat", 32'(lat), 32'(TO + 1));
      ack_en = 1'b1; ack_delay = 0; rd_data = 16'hC3C3;
      sb.push_back('{idx: 0, err: 1'b0, data: 16'hC3C3});
      @(negedge clk);
      check("to_next_grant", 32'(grant), 32'd0);
      m_request = 3'b000;
      wait_resp("to_next", 10, lat);
      last_read = 16'hC3C3;

      // Request dropped and inputs changed mid-transaction.
      ack_delay = 3; rd_data = 16'h5A5A;
      set_master(1, 1'b0, 16'h0077, 16'h0000);
      m_request = 3'b010;
      sb.push_back('{idx: 1, err: 1'b0, data: 16'h5A5A});
      @(negedge clk);
      check("drop_loc", 32'(mem_locator), 32'h0077);
      m_request = 3'b000;
      set_master(1, 1'b1, 16'hFFFF, 16'hEEEE);
      @(negedge clk);
      check("drop_loc_hold",  32'(mem_locator), 32'h0077);
      check("drop_mode_hold", 32'(mem_mode),    32'd0);
      wait_resp("drop", 10, lat);
      last_read = 16'h5A5A;

      // Reset mid-BUSY, then a late ack that must be ignored.
      ack_en = 1'b0;
      set_master(1, 1'b0, 16'h0055, 16'h0000);
      m_request = 3'b010;
      @(negedge clk);
      check("rst_busy_req", 32'(mem_request), 32'd1);
      reset = 1'b1;
      m_request = 3'b000;
      @(negedge clk);
      check_quiet("rst_mid");
      check("rst_mid_read",  32'(m_read), 32'd0);
      check("rst_mid_grant", 32'(grant),  32'd0);
      reset = 1'b0;
      man_resp = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check("late_resp", 32'(m_response),  32'd0);
         check("late_req",  32'(mem_request), 32'd0);
      end
      man_resp = 1'b0;
      check("sb_empty", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
